// File: rtl/serial_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_rx_pkg                                                              |
// | Shared constants and FSM state encoding for the FTDI serial receiver.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package serial_rx_pkg;

  // 12 MHz / 115200 baud, rounded; shared with serial_tx
  localparam int c_baud_div_default = 104;

  // Extra high samples required in WAIT_IDLE before leaving it.
  // This covers the reset value still flushing out of the synchronizer.
  localparam int c_idle_settle = 2;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_sync                                                                |
// | Two-flop synchronizer for asynchronous serial control lines.               |
// | Output resets high, which is the idle level of the line.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_sync (
  input  logic clk12,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
    end
  end

  assign sync_out = r_sync;

endmodule
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_rx                                                                  |
// | 8N1 UART receiver, LSB first, with a one-byte valid/ack holding register.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int BAUD_DIV = c_baud_div_default,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk12,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rbyte,
  output logic       rbyte_valid,
  input  logic       rbyte_ack,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);

  localparam int c_div_w = $clog2(BAUD_DIV);

  logic             w_rx_s;
  rx_state_t        r_state;
  logic [c_div_w-1:0] r_div;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_rx_prev;

  serial_sync u_sync (
    .clk12    (clk12),
    .reset    (reset),
    .async_in (rx),
    .sync_out (w_rx_s)
  );

  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) begin
      r_state     <= WAIT_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_rx_prev   <= 1'b1;
      rbyte       <= '0;
      rbyte_valid <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b1;
    end else begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      r_rx_prev   <= w_rx_s;

      if (rbyte_valid && rbyte_ack)
        rbyte_valid <= 1'b0;

      case (r_state)
        WAIT_IDLE: begin
          if (!w_rx_s) begin
            r_div <= '0;
          end else if (r_div == c_div_w'(c_idle_settle)) begin
            r_state <= IDLE;
            r_div   <= '0;
            busy    <= 1'b0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        IDLE: begin
          if (r_rx_prev && !w_rx_s) begin
            r_state <= START;
            // the edge-detect cycle already counts toward the half bit
            r_div   <= c_div_w'(1);
            busy    <= 1'b1;
          end
        end

        START: begin
          if (r_div == c_div_w'(HALF_DIV - 1)) begin
            r_div <= '0;
            if (!w_rx_s) begin
              r_state <= DATA;
              r_bit   <= '0;
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        DATA: begin
          if (r_div == c_div_w'(BAUD_DIV - 1)) begin
            r_div   <= '0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            if (r_bit == 3'd7)
              r_state <= STOP;
            else
              r_bit <= r_bit + 1'b1;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        STOP: begin
          if (r_div == c_div_w'(BAUD_DIV - 1)) begin
            r_div <= '0;
            if (w_rx_s) begin
              r_state <= IDLE;
              busy    <= 1'b0;
              if (!rbyte_valid || rbyte_ack) begin
                rbyte       <= r_shift;
                rbyte_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              r_state     <= WAIT_IDLE;
              framing_err <= 1'b1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        default: begin
          r_state <= WAIT_IDLE;
          r_div   <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_rx                                                               |
// | Directed bench for serial_rx with an expected-byte scoreboard.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_serial_rx;

  localparam int BIT_CYC = 104;

  logic       clk12 = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rbyte_ack = 1'b0;
  logic [7:0] rbyte;
  logic       rbyte_valid;
  logic       framing_err;
  logic       overrun;
  logic       busy;

  serial_rx #(.BAUD_DIV(BIT_CYC)) dut (
    .clk12       (clk12),
    .reset       (reset),
    .rx          (rx),
    .rbyte       (rbyte),
    .rbyte_valid (rbyte_valid),
    .rbyte_ack   (rbyte_ack),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk12 = ~clk12;

  int cyc = 0;
  always @(posedge clk12) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int deliv_cnt = 0;
  int valid_rise_cyc = 0;
  int frame_start = 0;
  logic auto_ack = 1'b0;
  logic ack_sync = 1'b0;
  logic manual_ack = 1'b0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk12);
    rx = 1'b0;
    frame_start = cyc;
    repeat (BIT_CYC - 1) @(negedge clk12);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk12);
      rx = b[i];
      repeat (BIT_CYC - 1) @(negedge clk12);
    end
    @(negedge clk12);
    rx = stop_bit;
    repeat (BIT_CYC - 1) @(negedge clk12);
  endtask

  task automatic expect_byte(input string tag);
    int n;
    n = 0;
    while (!rbyte_valid && n < 1200) begin
      @(negedge clk12);
      n++;
    end
    if (!rbyte_valid)
      check({tag, "_timeout"}, 32'(rbyte_valid), 32'd1);
    else if (exp_q.size() == 0)
      check({tag, "_unexpected"}, 32'(rbyte), 32'h100);
    else
      check(tag, 32'(rbyte), 32'(exp_q.pop_front()));
  endtask

  task automatic do_ack();
    manual_ack = 1'b1;
    repeat (4) @(negedge clk12);
  endtask

  // Monitor: event counters, auto-ack scoreboard pops, and the single driver of rbyte_ack.
  initial forever begin
    @(negedge clk12);
    if (framing_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (framing_err || overrun)
      check("fe_ov_exclusive", 32'(framing_err & overrun), 32'd0);
    if (rbyte_valid && !prev_valid) begin
      deliv_cnt++;
      valid_rise_cyc = cyc;
    end
    prev_valid = rbyte_valid;
    if (auto_ack && rbyte_valid && !rbyte_ack) begin
      if (exp_q.size() == 0)
        check("auto_unexpected", 32'(rbyte), 32'h100);
      else
        check("auto_byte", 32'(rbyte), 32'(exp_q.pop_front()));
      rbyte_ack = 1'b1;
    end else if (ack_sync && cyc == frame_start + 989) begin
      rbyte_ack = 1'b1;
    end else if (manual_ack) begin
      rbyte_ack  = 1'b1;
      manual_ack = 1'b0;
    end else begin
      rbyte_ack = 1'b0;
    end
  end

  initial begin
    string msg;
    int n;
    msg = "Hello World!";

    // Reset values
    repeat (3) @(negedge clk12);
    check("rst_rbyte", 32'(rbyte), 32'h00);
    check("rst_valid", 32'(rbyte_valid), 32'd0);
    check("rst_fe", 32'(framing_err), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    repeat (10) @(negedge clk12);
    check("idle_busy", 32'(busy), 32'd0);

    // 1: single byte, latency
    fe_cnt = 0; ov_cnt = 0;
    exp_q.push_back(8'h48);
    send_byte(8'h48, 1'b1);
    expect_byte("t1_byte");
    check("t1_latency_ok", 32'((valid_rise_cyc - frame_start >= 989) && (valid_rise_cyc - frame_start <= 991)), 32'd1);
    check("t1_fe", 32'(fe_cnt), 32'd0);
    check("t1_ov", 32'(ov_cnt), 32'd0);
    do_ack();
    check("t1_valid_after_ack", 32'(rbyte_valid), 32'd0);

    // 2: back-to-back string with auto-ack
    deliv_cnt = 0;
    for (int i = 0; i < msg.len(); i++) exp_q.push_back(msg[i]);
    auto_ack = 1'b1;
    for (int i = 0; i < msg.len(); i++) send_byte(msg[i], 1'b1);
    n = 0;
    while ((exp_q.size() != 0 || rbyte_valid) && n < 2000) begin
      @(negedge clk12);
      n++;
    end
    auto_ack = 1'b0;
    check("t2_left_in_queue", 32'(exp_q.size()), 32'd0);
    check("t2_deliveries", 32'(deliv_cnt), 32'd12);
    check("t2_fe", 32'(fe_cnt), 32'd0);
    check("t2_ov", 32'(ov_cnt), 32'd0);

    // 3a: overrun, old byte kept
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    expect_byte("t3a_first");
    send_byte(8'hAA, 1'b1);
    check("t3a_rbyte_kept", 32'(rbyte), 32'h55);
    check("t3a_valid", 32'(rbyte_valid), 32'd1);
    check("t3a_ov", 32'(ov_cnt), 32'd1);
    do_ack();
    check("t3a_valid_after_ack", 32'(rbyte_valid), 32'd0);

    // 3b: ack coincident with delivery replaces the byte
    ov_cnt = 0;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    expect_byte("t3b_first");
    exp_q.push_back(8'hAA);
    ack_sync = 1'b1;
    send_byte(8'hAA, 1'b1);
    ack_sync = 1'b0;
    expect_byte("t3b_second");
    check("t3b_ov", 32'(ov_cnt), 32'd0);
    do_ack();

    // 4: framing error followed by break
    fe_cnt = 0; deliv_cnt = 0;
    send_byte(8'h00, 1'b0);
    repeat (2000) @(negedge clk12);
    check("t4_busy_in_break", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (20) @(negedge clk12);
    check("t4_fe", 32'(fe_cnt), 32'd1);
    check("t4_deliveries", 32'(deliv_cnt), 32'd0);
    check("t4_busy_after", 32'(busy), 32'd0);
    exp_q.push_back(8'h31);
    send_byte(8'h31, 1'b1);
    expect_byte("t4_next_byte");
    do_ack();

    // 5: short glitch
    fe_cnt = 0; deliv_cnt = 0;
    repeat (20) @(negedge clk12);
    rx = 1'b0;
    repeat (10) @(negedge clk12);
    check("t5_busy_in_start", 32'(busy), 32'd1);
    repeat (10) @(negedge clk12);
    rx = 1'b1;
    repeat (100) @(negedge clk12);
    check("t5_busy_after", 32'(busy), 32'd0);
    check("t5_deliveries", 32'(deliv_cnt), 32'd0);
    check("t5_fe", 32'(fe_cnt), 32'd0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    expect_byte("t5_next_byte");
    do_ack();

    // 6a: reset during bit 4 of 0xC3, released with rx high
    deliv_cnt = 0;
    @(negedge clk12);
    rx = 1'b0;
    repeat (BIT_CYC - 1) @(negedge clk12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk12);
      rx = (8'hC3 >> i) & 8'h01;
      repeat ((i == 4) ? 50 : BIT_CYC - 1) @(negedge clk12);
    end
    reset = 1'b1;
    @(negedge clk12);
    check("t6_rst_rbyte", 32'(rbyte), 32'h00);
    check("t6_rst_valid", 32'(rbyte_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (5) @(negedge clk12);
    reset = 1'b0;
    repeat (20) @(negedge clk12);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    expect_byte("t6a_byte");
    check("t6a_deliveries", 32'(deliv_cnt), 32'd1);
    do_ack();

    // 6b: reset released with rx low
    deliv_cnt = 0; fe_cnt = 0;
    @(negedge clk12);
    rx = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk12);
    reset = 1'b0;
    repeat (1200) @(negedge clk12);
    check("t6b_busy_low", 32'(busy), 32'd1);
    check("t6b_deliveries", 32'(deliv_cnt), 32'd0);
    check("t6b_fe", 32'(fe_cnt), 32'd0);
    rx = 1'b1;
    repeat (20) @(negedge clk12);
    check("t6b_busy_high", 32'(busy), 32'd0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    expect_byte("t6b_byte");
    do_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
